// File: rtl/gopf_pkg.sv
// Shared constants, state encoding and word helper for the GOPF_MUL
// word-serial front/back end.
package gopf_pkg;

    localparam int W    = 16;
    localparam int NW   = 9;
    localparam int M    = W * NW;
    localparam int NOPS = 3;
    localparam int CW   = $clog2(NOPS * NW);
    localparam int RW   = $clog2(NW);

    typedef enum logic [1:0] {
        S_LOAD,
        S_START,
        S_WAIT,
        S_UNLOAD
    } state_t;

    // Word k of a 144-bit vector; w0 is the leftmost slice.
    function automatic logic [0:W-1] word_of(
        input logic [0:M-1]  v,
        input logic [RW-1:0] k
    );
        return v[int'(k)*W +: W];
    endfunction

endpackage

// File: rtl/gopf_word_sreg.sv
// 144-bit register with 16-bit indexed word write and full-width load.
// Full load has priority over a word write.
module gopf_word_sreg
    import gopf_pkg::*;
(
    input  logic          clk,
    input  logic          rst_b,
    input  logic          we_i,
    input  logic [RW-1:0] widx_i,
    input  logic [0:W-1]  wdata_i,
    input  logic          ld_i,
    input  logic [0:M-1]  ldata_i,
    output logic [0:M-1]  q_o
);

    logic [0:M-1] q_q;
    logic [0:M-1] q_d;

    // Next value: whole-vector load, else single word write, else hold.
    always_comb begin
        q_d = q_q;
        if (ld_i) begin
            q_d = ldata_i;
        end else if (we_i) begin
            q_d[int'(widx_i)*W +: W] = wdata_i;
        end
    end

    // Storage.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/gopf_mul_io.sv
// Word-serial load / start / capture / unload wrapper around GOPF_MUL.
// Optional WAIT timeout abort is built in with GOPF_IO_TIMEOUT_EN.
module gopf_mul_io
    import gopf_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:W-1] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:W-1] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         err,
    output logic         core_start,
    output logic [0:M-1] core_multiplicand,
    output logic [0:M-1] core_multiplier,
    output logic [0:M-1] core_mod,
    input  logic [0:M-1] core_mul_out,
    input  logic         core_mul_done
);

    state_t        state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          acc;
    logic          we_a, we_b, we_m;
    logic [RW-1:0] widx;
    logic          res_ld;
    logic [0:M-1]  res_in;
    logic [0:M-1]  res_w;
    logic          to_hit;

    assign in_ready   = (state_q == S_LOAD);
    assign out_valid  = (state_q == S_UNLOAD);
    assign core_start = (state_q == S_START);
    assign busy       = !((state_q == S_LOAD) && (wcnt_q == '0));
    assign out_last   = out_valid && (rcnt_q == RW'(NW - 1));
    assign out_data   = out_valid ? word_of(res_w, rcnt_q) : '0;
    assign acc        = in_valid && in_ready;
    assign res_in     = core_mul_done ? core_mul_out : '0;

    // Route an accepted word to its operand and word slot.
    always_comb begin
        we_a = 1'b0;
        we_b = 1'b0;
        we_m = 1'b0;
        widx = '0;
        unique case (1'b1)
            (wcnt_q < CW'(NW)): begin
                we_a = acc;
                widx = RW'(wcnt_q);
            end
            (wcnt_q >= CW'(NW)) && (wcnt_q < CW'(2 * NW)): begin
                we_b = acc;
                widx = RW'(wcnt_q - CW'(NW));
            end
            (wcnt_q >= CW'(2 * NW)): begin
                we_m = acc;
                widx = RW'(wcnt_q - CW'(2 * NW));
            end
        endcase
    end

    // Control FSM next state and counters.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        res_ld  = 1'b0;
        unique case (state_q)
            S_LOAD: begin
                if (acc) begin
                    if (wcnt_q == CW'(NOPS * NW - 1)) begin
                        wcnt_d  = '0;
                        state_d = S_START;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_mul_done || to_hit) begin
                    res_ld  = 1'b1;
                    rcnt_d  = '0;
                    state_d = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                if (out_ready) begin
                    if (rcnt_q == RW'(NW - 1)) begin
                        rcnt_d  = '0;
                        state_d = S_LOAD;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_LOAD;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
        end
    end

`ifdef GOPF_IO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);

    logic [TW-1:0] tcnt_q;
    logic          err_q;

    assign to_hit = (state_q == S_WAIT) && !core_mul_done &&
                    (tcnt_q == TW'(TIMEOUT - 1));
    assign err    = err_q;

    // WAIT cycle counter, restarted by each START.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            tcnt_q <= '0;
        end else if (state_q == S_START) begin
            tcnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            tcnt_q <= tcnt_q + 1'b1;
        end
    end

    // Abort flag, held until the next accepted input word.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            err_q <= 1'b0;
        end else if (acc) begin
            err_q <= 1'b0;
        end else if (to_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
    assign err    = 1'b0;

    // TIMEOUT is only consumed by the abort counter.
    if (TIMEOUT < 2) begin : g_to_unused
    end
`endif

    gopf_word_sreg u_mcand (
        .clk     (clk),
        .rst_b   (rst_b),
        .we_i    (we_a),
        .widx_i  (widx),
        .wdata_i (in_data),
        .ld_i    (1'b0),
        .ldata_i ({M{1'b0}}),
        .q_o     (core_multiplicand)
    );

    gopf_word_sreg u_mplier (
        .clk     (clk),
        .rst_b   (rst_b),
        .we_i    (we_b),
        .widx_i  (widx),
        .wdata_i (in_data),
        .ld_i    (1'b0),
        .ldata_i ({M{1'b0}}),
        .q_o     (core_multiplier)
    );

    gopf_word_sreg u_mod (
        .clk     (clk),
        .rst_b   (rst_b),
        .we_i    (we_m),
        .widx_i  (widx),
        .wdata_i (in_data),
        .ld_i    (1'b0),
        .ldata_i ({M{1'b0}}),
        .q_o     (core_mod)
    );

    gopf_word_sreg u_result (
        .clk     (clk),
        .rst_b   (rst_b),
        .we_i    (1'b0),
        .widx_i  ({RW{1'b0}}),
        .wdata_i ({W{1'b0}}),
        .ld_i    (res_ld),
        .ldata_i (res_in),
        .q_o     (res_w)
    );

endmodule

// File: tb/tb_gopf_mul_io.sv
// Randomized self-checking bench for gopf_mul_io with an in-bench
// stub of the GOPF_MUL core.
module tb_gopf_mul_io;
    import gopf_pkg::*;

    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_b = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [0:W-1] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [0:W-1] out_data;
    logic         out_last;
    logic         busy;
    logic         err;
    logic         core_start;
    logic [0:M-1] cm, cmr, cmod;
    logic [0:M-1] core_mul_out = '0;
    logic         core_mul_done = 1'b0;

    always #5 clk = ~clk;

    gopf_mul_io #(.TIMEOUT(TO)) dut (
        .clk               (clk),
        .rst_b             (rst_b),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_last          (out_last),
        .busy              (busy),
        .err               (err),
        .core_start        (core_start),
        .core_multiplicand (cm),
        .core_multiplier   (cmr),
        .core_mod          (cmod),
        .core_mul_out      (core_mul_out),
        .core_mul_done     (core_mul_done)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [W-1:0] ow[27];
    logic [W-1:0] rw[9];

    task automatic check(input string tag, input logic [M-1:0] got,
                         input logic [M-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_core_start"}, core_start, 0);
        check({tag, "_mcand"}, cm, 0);
        check({tag, "_mplier"}, cmr, 0);
        check({tag, "_mod"}, cmod, 0);
    endtask

    task automatic fill_ops;
        for (int i = 0; i < 27; i++) ow[i] = W'($urandom);
    endtask

    task automatic fill_res;
        for (int k = 0; k < 9; k++) rw[k] = W'($urandom);
    endtask

    // Send words ow[0..n-1]; pv is the percent chance in_valid is high.
    task automatic load(input int n, input int pv);
        int i = 0;
        int budget = 0;
        while (i < n && budget < 2000) begin
            in_valid = ($urandom_range(99) < pv);
            in_data  = in_valid ? ow[i] : W'($urandom);
            check("load_in_ready", in_ready, 1);
            check("load_start_low", core_start, 0);
            check("load_out_valid", out_valid, 0);
            tick;
            if (in_valid) i++;
            budget++;
        end
        in_valid = 1'b0;
        if (i < n) check("load_budget", 0, 1);
    endtask

    task automatic check_operands(input string tag);
        for (int k = 0; k < 9; k++) begin
            check({tag, "_mcand_w"}, cm[k*W +: W], ow[k]);
            check({tag, "_mplier_w"}, cmr[k*W +: W], ow[9+k]);
            check({tag, "_mod_w"}, cmod[k*W +: W], ow[18+k]);
        end
    endtask

    // Called in the cycle after the 27th accept: expect one START cycle.
    task automatic check_start;
        check("start_pulse", core_start, 1);
        check("start_in_ready", in_ready, 0);
        check("start_busy", busy, 1);
        check_operands("start");
        tick;
        check("start_single", core_start, 0);
        check("wait_busy", busy, 1);
        check("wait_in_ready", in_ready, 0);
    endtask

    // Stub core: done after dly WAIT cycles carrying rw, then garbage.
    task automatic core_respond(input int dly);
        logic [0:M-1] v;
        for (int k = 0; k < 9; k++) v[k*W +: W] = rw[k];
        for (int j = 0; j < dly; j++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            check("wait_out_valid", out_valid, 0);
            check("wait_start_low", core_start, 0);
            tick;
        end
        in_valid      = 1'b0;
        core_mul_out  = v;
        core_mul_done = 1'b1;
        tick;
        core_mul_done = 1'b0;
        core_mul_out  = ~v;
        check("done_to_valid", out_valid, 1);
        check_operands("frozen");
    endtask

    // Drain 9 words; stall 5 cycles when word stall_at is presented.
    task automatic unload(input int stall_at, input int pr);
        int k = 0;
        int budget = 0;
        int st = 0;
        while (k < 9 && budget < 500) begin
            if (k == stall_at && st < 5) begin
                out_ready = 1'b0;
                st++;
            end else begin
                out_ready = ($urandom_range(99) < pr);
            end
            check("out_valid", out_valid, 1);
            check("out_data", out_data, rw[k]);
            check("out_last", out_last, (k == 8));
            check("unload_in_ready", in_ready, 0);
            tick;
            if (out_ready) k++;
            budget++;
        end
        out_ready = 1'b0;
        if (k < 9) check("unload_budget", 0, 1);
        check("end_out_valid", out_valid, 0);
        check("end_in_ready", in_ready, 1);
        check("end_busy", busy, 0);
        check("end_out_last", out_last, 0);
        check("end_out_data", out_data, 0);
    endtask

    initial begin
        // Reset values
        rst_b = 1'b0;
        tick;
        tick;
        check_reset_outs("reset");
        rst_b = 1'b1;
        tick;
        check_reset_outs("post_reset");

        // Identity multiply with a stall at word 3
        for (int i = 0; i < 9; i++) ow[i] = W'(i + 1);
        for (int i = 9; i < 18; i++) ow[i] = '0;
        ow[17] = 16'h0001;
        for (int i = 18; i < 27; i++) ow[i] = W'($urandom);
        for (int k = 0; k < 9; k++) rw[k] = ow[k];
        load(27, 100);
        check_start();
        core_respond(3);
        unload(3, 100);

        // Random gaps, stray done in LOAD, back-to-back ops
        for (int op = 0; op < 6; op++) begin
            fill_ops();
            fill_res();
            core_mul_done = 1'b1;
            core_mul_out  = {NW{16'hDEAD}};
            tick;
            core_mul_done = 1'b0;
            check("stray_done", out_valid, 0);
            load(27, 50);
            check_start();
            core_respond($urandom_range(8));
            unload(op % 9, 60);
            check("no_err", err, 0);
        end

        // Async reset in the middle of loading
        fill_ops();
        load(13, 70);
        check("mid_busy", busy, 1);
        rst_b = 1'b0;
        #1;
        check_reset_outs("async_reset");
        tick;
        rst_b = 1'b1;
        tick;
        check_reset_outs("after_abort");
        fill_ops();
        fill_res();
        load(27, 80);
        check_start();
        core_respond(2);
        unload(-1, 70);

        // All-ones result followed by zero on the next cycle
        fill_ops();
        for (int k = 0; k < 9; k++) rw[k] = 16'hFFFF;
        load(27, 100);
        check_start();
        core_respond(1);
        unload(-1, 50);

`ifdef GOPF_IO_TIMEOUT_EN
        // Core never answers: abort after TO WAIT cycles
        fill_ops();
        load(27, 100);
        check_start();
        for (int j = 0; j < TO; j++) begin
            check("to_err_low", err, 0);
            check("to_no_valid", out_valid, 0);
            tick;
        end
        check("to_err_set", err, 1);
        for (int k = 0; k < 9; k++) rw[k] = '0;
        unload(-1, 70);
        check("to_err_sticky", err, 1);
        fill_ops();
        fill_res();
        load(27, 100);
        check("to_err_cleared", err, 0);
        check_start();
        core_respond(4);
        unload(-1, 100);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
